// File: rtl/agc_stats_pkg.sv
// Shared types, constants and width helpers for the AGC statistics engine.
package agc_stats_pkg;

   // Measurement sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Clocks needed to flush the square/tree/accumulate pipeline after RUN
   localparam int unsigned DRAIN_LEN = 3;

   // Full-precision sum-of-squares width for one window
   function automatic int unsigned sq_bits(input int unsigned sample_bits,
                                           input int unsigned nsamp,
                                           input int unsigned window_bits);
      return 2 * sample_bits + $clog2(nsamp) + window_bits;
   endfunction

   // Full-precision threshold-count width for one window
   function automatic int unsigned cnt_bits(input int unsigned nsamp,
                                            input int unsigned window_bits);
      return window_bits + $clog2(nsamp) + 1;
   endfunction

endpackage

// File: rtl/agc_stats_chan.sv
// One channel: input register, square/compare, adder tree, accumulate, results.
// Peak |sample| tracking is built only when AGC_STATS_PEAK_EN is defined.
module agc_stats_chan
   import agc_stats_pkg::*;
#(
   parameter  int unsigned NSAMP       = 8,
   parameter  int unsigned SAMPLE_BITS = 12,
   parameter  int unsigned WINDOW_BITS = 17,
   localparam int unsigned SQ_BITS     = sq_bits(SAMPLE_BITS, NSAMP, WINDOW_BITS),
   localparam int unsigned CNT_BITS    = cnt_bits(NSAMP, WINDOW_BITS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NSAMP*SAMPLE_BITS-1:0] dat,
   input  logic [SAMPLE_BITS-2:0]       thresh,
   input  logic                         valid,
   input  logic                         acc_clr,
   input  logic                         latch,
   input  logic                         res_clr,
`ifdef AGC_STATS_PEAK_EN
   output logic [SAMPLE_BITS-1:0]       pk,
`endif
   output logic [SQ_BITS-1:0]           sq,
   output logic [CNT_BITS-1:0]          gt,
   output logic [CNT_BITS-1:0]          lt
);

   localparam int unsigned PW    = 2 * SAMPLE_BITS;
   localparam int unsigned SUM_W = PW + $clog2(NSAMP);
   localparam int unsigned TC_W  = $clog2(NSAMP) + 1;

   logic [NSAMP*SAMPLE_BITS-1:0] s1_dat;
   logic                         s1_vld;
   logic [PW-1:0]                s2_sq_d [NSAMP];
   logic [NSAMP-1:0]             s2_gt_d;
   logic [NSAMP-1:0]             s2_lt_d;
   logic [PW-1:0]                s2_sq   [NSAMP];
   logic [NSAMP-1:0]             s2_gt;
   logic [NSAMP-1:0]             s2_lt;
   logic                         s2_vld;
   logic signed [SAMPLE_BITS:0]  thr;
   logic signed [SAMPLE_BITS:0]  smp;
   logic signed [PW-1:0]         sx;
   logic [SUM_W-1:0]             tr_sq;
   logic [TC_W-1:0]              tr_gt;
   logic [TC_W-1:0]              tr_lt;
   logic [SUM_W-1:0]             s3_sq;
   logic [TC_W-1:0]              s3_gt;
   logic [TC_W-1:0]              s3_lt;
   logic                         s3_vld;
   logic [SQ_BITS-1:0]           acc_sq;
   logic [CNT_BITS-1:0]          acc_gt;
   logic [CNT_BITS-1:0]          acc_lt;

   // Stage 1: input register; a restart kills the beat in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_dat <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_dat <= dat;
         s1_vld <= valid & ~acc_clr;
      end
   end

   // Stage 2 logic: sign-extended square and strict +/-thresh compares
   always_comb begin
      thr = $signed({2'b00, thresh});
      smp = '0;
      sx  = '0;
      for (int s = 0; s < NSAMP; s++) begin
         smp        = $signed({s1_dat[s*SAMPLE_BITS + SAMPLE_BITS - 1],
                                s1_dat[s*SAMPLE_BITS +: SAMPLE_BITS]});
         sx         = PW'(smp);
         s2_sq_d[s] = PW'(sx * sx);
         s2_gt_d[s] = smp > thr;
         s2_lt_d[s] = smp < -thr;
      end
   end

   // Stage 2 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSAMP; s++) s2_sq[s] <= '0;
         s2_gt  <= '0;
         s2_lt  <= '0;
         s2_vld <= 1'b0;
      end else begin
         for (int s = 0; s < NSAMP; s++) s2_sq[s] <= s2_sq_d[s];
         s2_gt  <= s2_gt_d;
         s2_lt  <= s2_lt_d;
         s2_vld <= s1_vld & ~acc_clr;
      end
   end

   // Stage 3 logic: sum squares and counts across the beat
   always_comb begin
      tr_sq = '0;
      tr_gt = '0;
      tr_lt = '0;
      for (int s = 0; s < NSAMP; s++) begin
         tr_sq = tr_sq + SUM_W'(s2_sq[s]);
         tr_gt = tr_gt + TC_W'(s2_gt[s]);
         tr_lt = tr_lt + TC_W'(s2_lt[s]);
      end
   end

   // Stage 3 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_sq  <= '0;
         s3_gt  <= '0;
         s3_lt  <= '0;
         s3_vld <= 1'b0;
      end else begin
         s3_sq  <= tr_sq;
         s3_gt  <= tr_gt;
         s3_lt  <= tr_lt;
         s3_vld <= s2_vld & ~acc_clr;
      end
   end

   // Stage 4: window accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_sq <= '0;
         acc_gt <= '0;
         acc_lt <= '0;
      end else if (acc_clr) begin
         acc_sq <= '0;
         acc_gt <= '0;
         acc_lt <= '0;
      end else if (s3_vld) begin
         acc_sq <= acc_sq + SQ_BITS'(s3_sq);
         acc_gt <= acc_gt + CNT_BITS'(s3_gt);
         acc_lt <= acc_lt + CNT_BITS'(s3_lt);
      end
   end

   // Result registers hold the last completed window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq <= '0;
         gt <= '0;
         lt <= '0;
      end else if (res_clr) begin
         sq <= '0;
         gt <= '0;
         lt <= '0;
      end else if (latch) begin
         sq <= acc_sq;
         gt <= acc_gt;
         lt <= acc_lt;
      end
   end

`ifdef AGC_STATS_PEAK_EN
   localparam logic [SAMPLE_BITS-1:0] SMIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
   localparam logic [SAMPLE_BITS-1:0] SMAX = ~SMIN;

   logic [SAMPLE_BITS-1:0] ab_d [NSAMP];
   logic [SAMPLE_BITS-1:0] s2_ab [NSAMP];
   logic [SAMPLE_BITS-1:0] v;
   logic [SAMPLE_BITS-1:0] tr_pk;
   logic [SAMPLE_BITS-1:0] s3_pk;
   logic [SAMPLE_BITS-1:0] acc_pk;

   // Saturating magnitude per sample (most negative maps to max positive)
   always_comb begin
      v = '0;
      for (int s = 0; s < NSAMP; s++) begin
         v = s1_dat[s*SAMPLE_BITS +: SAMPLE_BITS];
         if (v == SMIN)               ab_d[s] = SMAX;
         else if (v[SAMPLE_BITS-1])   ab_d[s] = -v;
         else                         ab_d[s] = v;
      end
   end

   // Beat maximum magnitude
   always_comb begin
      tr_pk = '0;
      for (int s = 0; s < NSAMP; s++) begin
         if (s2_ab[s] > tr_pk) tr_pk = s2_ab[s];
      end
   end

   // Peak pipeline, accumulator and result, aligned with the energy path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NSAMP; s++) s2_ab[s] <= '0;
         s3_pk  <= '0;
         acc_pk <= '0;
         pk     <= '0;
      end else begin
         for (int s = 0; s < NSAMP; s++) s2_ab[s] <= ab_d[s];
         s3_pk <= tr_pk;
         if (acc_clr)                      acc_pk <= '0;
         else if (s3_vld && s3_pk > acc_pk) acc_pk <= s3_pk;
         if (res_clr)    pk <= '0;
         else if (latch) pk <= acc_pk;
      end
   end
`endif

endmodule

// File: rtl/agc_stats_engine.sv
// Multi-channel AGC statistics engine: run sequencer, config capture, readback.
// Optional peak tracking: define AGC_STATS_PEAK_EN.
module agc_stats_engine
   import agc_stats_pkg::*;
#(
   parameter  int unsigned NCHAN       = 8,
   parameter  int unsigned NSAMP       = 8,
   parameter  int unsigned SAMPLE_BITS = 12,
   parameter  int unsigned WINDOW_BITS = 17,
   localparam int unsigned SQ_BITS     = sq_bits(SAMPLE_BITS, NSAMP, WINDOW_BITS),
   localparam int unsigned CNT_BITS    = cnt_bits(NSAMP, WINDOW_BITS),
   localparam int unsigned RD_BITS     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] dat_i,
   input  logic                               start_i,
   input  logic                               clr_i,
   input  logic                               auto_i,
   input  logic [WINDOW_BITS-1:0]             window_i,
   input  logic [SAMPLE_BITS-2:0]             thresh_i,
   input  logic [RD_BITS-1:0]                 rd_chan_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               update_o,
   output logic [SQ_BITS-1:0]                 sq_o,
   output logic [CNT_BITS-1:0]                gt_o,
   output logic [CNT_BITS-1:0]                lt_o,
   output logic [SAMPLE_BITS-1:0]             pk_o
);

   state_t                 state;
   logic [WINDOW_BITS-1:0] cnt;
   logic [WINDOW_BITS-1:0] win_m1_q;
   logic [WINDOW_BITS-1:0] win_m1_c;
   logic [SAMPLE_BITS-2:0] thresh_q;
   logic                   auto_q;
   logic                   run_c;
   logic                   latch_c;
   logic                   acc_clr_c;

   logic [SQ_BITS-1:0]     ch_sq [NCHAN];
   logic [CNT_BITS-1:0]    ch_gt [NCHAN];
   logic [CNT_BITS-1:0]    ch_lt [NCHAN];
`ifdef AGC_STATS_PEAK_EN
   logic [SAMPLE_BITS-1:0] ch_pk [NCHAN];
`endif

   // Channel strobes; a start or clear overrides any in-progress sampling or latch
   always_comb begin
      win_m1_c  = (window_i == '0) ? '0 : window_i - 1'b1;
      run_c     = (state == ST_RUN)   && !start_i && !clr_i;
      latch_c   = (state == ST_LATCH) && !start_i && !clr_i;
      acc_clr_c = start_i || clr_i || (latch_c && auto_q);
   end

   // Run sequencer: IDLE -> RUN (W) -> DRAIN (3) -> LATCH (1) -> RUN/IDLE
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         win_m1_q <= '0;
         thresh_q <= '0;
         auto_q   <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         update_o <= 1'b0;
      end else begin
         update_o <= 1'b0;
         if (clr_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            auto_q <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
         end else if (start_i) begin
            state    <= ST_RUN;
            cnt      <= win_m1_c;
            win_m1_q <= win_m1_c;
            thresh_q <= thresh_i;
            auto_q   <= auto_i;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (cnt == '0) begin
                     state <= ST_DRAIN;
                     cnt   <= WINDOW_BITS'(DRAIN_LEN - 1);
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_DRAIN: begin
                  if (cnt == '0) state <= ST_LATCH;
                  else           cnt   <= cnt - 1'b1;
               end
               ST_LATCH: begin
                  done_o   <= 1'b1;
                  update_o <= 1'b1;
                  if (auto_q) begin
                     state <= ST_RUN;
                     cnt   <= win_m1_q;
                  end else begin
                     state  <= ST_IDLE;
                     busy_o <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Per-channel measurement pipelines
   for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      agc_stats_chan #(
         .NSAMP       (NSAMP),
         .SAMPLE_BITS (SAMPLE_BITS),
         .WINDOW_BITS (WINDOW_BITS)
      ) u_chan (
         .clk     (aclk),
         .rst_n   (aresetn),
         .dat     (dat_i[c*NSAMP*SAMPLE_BITS +: NSAMP*SAMPLE_BITS]),
         .thresh  (thresh_q),
         .valid   (run_c),
         .acc_clr (acc_clr_c),
         .latch   (latch_c),
         .res_clr (clr_i),
`ifdef AGC_STATS_PEAK_EN
         .pk      (ch_pk[c]),
`endif
         .sq      (ch_sq[c]),
         .gt      (ch_gt[c]),
         .lt      (ch_lt[c])
      );
   end

   // Registered readback mux; out-of-range selects read zero
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sq_o <= '0;
         gt_o <= '0;
         lt_o <= '0;
`ifdef AGC_STATS_PEAK_EN
         pk_o <= '0;
`endif
      end else if (32'(rd_chan_i) < NCHAN) begin
         sq_o <= ch_sq[rd_chan_i];
         gt_o <= ch_gt[rd_chan_i];
         lt_o <= ch_lt[rd_chan_i];
`ifdef AGC_STATS_PEAK_EN
         pk_o <= ch_pk[rd_chan_i];
`endif
      end else begin
         sq_o <= '0;
         gt_o <= '0;
         lt_o <= '0;
`ifdef AGC_STATS_PEAK_EN
         pk_o <= '0;
`endif
      end
   end

`ifndef AGC_STATS_PEAK_EN
   assign pk_o = '0;
`endif

endmodule

// File: tb/tb_agc_stats_engine.sv
// Scoreboard bench for agc_stats_engine: stimulus queues expected latches,
// a monitor pops and checks them on every update_o pulse.
module tb_agc_stats_engine;

   localparam int unsigned NCHAN = 8;
   localparam int unsigned NSAMP = 8;
   localparam int unsigned SB    = 12;
   localparam int unsigned WB    = 17;
   localparam int unsigned TW    = SB - 1;
   localparam int unsigned SQB   = 2 * SB + 3 + WB;
   localparam int unsigned CNB   = WB + 3 + 1;

   logic                       aclk = 1'b0;
   logic                       aresetn = 1'b1;
   logic [NCHAN*NSAMP*SB-1:0]  dat_i;
   logic                       start_i, clr_i, auto_i;
   logic [WB-1:0]              window_i;
   logic [TW-1:0]              thresh_i;
   logic [2:0]                 rd_chan_i;
   logic                       busy_o, done_o, update_o;
   logic [SQB-1:0]             sq_o;
   logic [CNB-1:0]             gt_o, lt_o;
   logic [SB-1:0]              pk_o;

   typedef struct {
      int     cyc;
      longint sq;
      int     gt;
      int     lt;
      int     pk;
      bit     busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   e1, e2;

   agc_stats_engine dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .dat_i     (dat_i),
      .start_i   (start_i),
      .clr_i     (clr_i),
      .auto_i    (auto_i),
      .window_i  (window_i),
      .thresh_i  (thresh_i),
      .rd_chan_i (rd_chan_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .update_o  (update_o),
      .sq_o      (sq_o),
      .gt_o      (gt_o),
      .lt_o      (lt_o),
      .pk_o      (pk_o)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      n_chk++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_chan(input int c, input int ve, input int vo);
      for (int s = 0; s < NSAMP; s++)
         dat_i[(c*NSAMP+s)*SB +: SB] = (s % 2 == 0) ? SB'(ve) : SB'(vo);
   endtask

   // Pulse start for one clock; returns the index of the edge that samples it
   task automatic start(input int w, input int th, input bit au, output int edge_no);
      window_i = WB'(w);
      thresh_i = TW'(th);
      auto_i   = au;
      start_i  = 1'b1;
      edge_no  = cyc + 1;
      tick();
      start_i  = 1'b0;
      auto_i   = 1'b0;
   endtask

   task automatic expect_upd(input int c, input longint sq, input int gt, input int lt,
                             input int pk, input bit busy);
      exp_t e;
      e.cyc  = c;
      e.sq   = sq;
      e.gt   = gt;
      e.lt   = lt;
`ifdef AGC_STATS_PEAK_EN
      e.pk   = pk;
`else
      e.pk   = 0;
`endif
      e.busy = busy;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("update_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) tick();
   endtask

   // Monitor: each update_o must match the oldest queued expectation
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge aclk);
         if (update_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_update", 32'(update_o), 0);
            end else begin
               e = exp_q.pop_front();
               chk("update_cycle", cyc, e.cyc);
               @(negedge aclk);
               chk("sq", sq_o, e.sq);
               chk("gt", gt_o, e.gt);
               chk("lt", lt_o, e.lt);
               chk("pk", pk_o, e.pk);
               chk("done", done_o, 1);
               chk("busy", busy_o, e.busy);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: bench did not finish, %0d checks, %0d errors", n_chk, n_err);
      $fatal(1);
   end

   initial begin : stim
      dat_i     = '0;
      start_i   = 1'b0;
      clr_i     = 1'b0;
      auto_i    = 1'b0;
      window_i  = '0;
      thresh_i  = '0;
      rd_chan_i = '0;
      #2 aresetn = 1'b0;
      #20 aresetn = 1'b1;
      tick();

      // Reset state
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_update", update_o, 0);
      chk("rst_sq", sq_o, 0);
      chk("rst_gt", gt_o, 0);
      chk("rst_lt", lt_o, 0);
      chk("rst_pk", pk_o, 0);

      // Constant 100 on ch0, thresh 50, window 16
      set_chan(0, 100, 100);
      rd_chan_i = 3'd0;
      start(16, 50, 1'b0, e1);
      chk("busy_after_start", busy_o, 1);
      expect_upd(e1 + 20, 1280000, 128, 0, 100, 1'b0);
      wait_drain(100);
      rd_chan_i = 3'd5;
      tick();
      tick();
      chk("idle_ch_sq", sq_o, 0);
      chk("idle_ch_gt", gt_o, 0);
      chk("idle_ch_pk", pk_o, 0);
      chk("done_sticky", done_o, 1);

      // Full-scale negative on ch3
      set_chan(0, 0, 0);
      set_chan(3, -2048, -2048);
      rd_chan_i = 3'd3;
      start(4, 2047, 1'b0, e1);
      chk("done_cleared_by_start", done_o, 0);
      expect_upd(e1 + 8, 134217728, 0, 32, 2047, 1'b0);
      wait_drain(100);

      // Threshold edge on ch1: equal magnitude counts nowhere, one less counts
      set_chan(3, 0, 0);
      set_chan(1, 50, -50);
      rd_chan_i = 3'd1;
      start(10, 50, 1'b0, e1);
      expect_upd(e1 + 14, 200000, 0, 0, 50, 1'b0);
      wait_drain(100);
      start(10, 49, 1'b0, e1);
      expect_upd(e1 + 14, 200000, 40, 40, 50, 1'b0);
      wait_drain(100);

      // Restart mid-run: window 100 then window 8 at edge 40
      set_chan(1, 0, 0);
      set_chan(0, 100, 100);
      rd_chan_i = 3'd0;
      start(100, 50, 1'b0, e1);
      repeat (39) tick();
      start(8, 50, 1'b0, e2);
      expect_upd(e2 + 12, 640000, 64, 0, 100, 1'b0);
      wait_drain(200);

      // Start coincident with LATCH suppresses that latch
      start(4, 50, 1'b0, e1);
      repeat (7) tick();
      start(4, 50, 1'b0, e2);
      expect_upd(e2 + 8, 320000, 32, 0, 100, 1'b0);
      wait_drain(100);

      // Reset asserted mid-run aborts without a latch
      start(20, 50, 1'b0, e1);
      repeat (10) tick();
      aresetn = 1'b0;
      #2;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_update", update_o, 0);
      chk("midrst_sq", sq_o, 0);
      chk("midrst_gt", gt_o, 0);
      chk("midrst_pk", pk_o, 0);
      #3 aresetn = 1'b1;
      repeat (30) tick();

      // Window 0 behaves as 1
      start(0, 50, 1'b0, e1);
      expect_upd(e1 + 5, 80000, 8, 0, 100, 1'b0);
      wait_drain(50);

      // Auto re-arm every W+4 clocks, then clear
      start(20, 50, 1'b1, e1);
      expect_upd(e1 + 24, 1600000, 160, 0, 100, 1'b1);
      expect_upd(e1 + 48, 1600000, 160, 0, 100, 1'b1);
      expect_upd(e1 + 72, 1600000, 160, 0, 100, 1'b1);
      wait_drain(150);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("clr_busy", busy_o, 0);
      chk("clr_done", done_o, 0);
      tick();
      chk("clr_sq", sq_o, 0);
      chk("clr_gt", gt_o, 0);
      repeat (40) tick();
      chk("clr_stays_idle", busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
